// File: rtl/stream_upsizer_pkg.sv
// Shared constants and width helpers for the stream upsizer family.
package stream_upsizer_pkg;

  localparam int DEFAULT_IN_W  = 4;
  localparam int DEFAULT_RATIO = 16;

  // Width of a beat count that must represent 0..ratio inclusive.
  function automatic int cw_of(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // Width of a slot pointer that ranges over 0..ratio-1.
  function automatic int ptr_w_of(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/upsizer_out_reg.sv
// Single-entry holding register with valid/ready load and drain logic.
// A load is allowed whenever the register is empty or draining this cycle,
// so a drain and a reload on the same edge keep valid high with no bubble.
module upsizer_out_reg #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          can_load
);

  assign can_load = !valid | ready;

  // Load wins over drain; payload holds its value after a drain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream gearbox: packs RATIO beats of IN_W bits into one
// word (beat 0 in the low slot), with early termination on enq_last that
// emits a zero-padded partial word plus its beat count.
module stream_upsizer
  import stream_upsizer_pkg::*;
#(
  parameter  int IN_W  = DEFAULT_IN_W,
  parameter  int RATIO = DEFAULT_RATIO,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CW    = cw_of(RATIO)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             enq_ready,
  input  logic             enq_valid,
  input  logic [IN_W-1:0]  enq_bits,
  input  logic             enq_last,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [OUT_W-1:0] deq_bits,
  output logic [CW-1:0]    deq_count,
  output logic             deq_last
);

  localparam int PW = ptr_w_of(RATIO);
  localparam int HW = OUT_W + CW + 1;

  logic [PW-1:0]   ptr;
  logic            enq_fire;
  logic            closing;
  logic [IN_W-1:0] acc [RATIO];
  logic [OUT_W-1:0] word;
  logic [CW-1:0]   count;
  logic [HW-1:0]   load_data;
  logic [HW-1:0]   held;

  assign enq_fire = enq_valid & enq_ready;
  assign closing  = enq_last | (ptr == PW'(RATIO - 1));

  // Slot pointer: advances per accepted beat, returns to 0 on the closing beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (enq_fire) begin
      ptr <= closing ? '0 : ptr + PW'(1);
    end
  end

  // Accumulator holds the non-closing beats; it needs no reset because the
  // word builder never reads slots at or above ptr.
  always_ff @(posedge clock) begin
    if (enq_fire && !closing) begin
      acc[ptr] <= enq_bits;
    end
  end

  // Word builder: stored slots below ptr, the live beat at ptr, zeros above.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
    assign word[gi*IN_W +: IN_W] = (PW'(gi) < ptr)  ? acc[gi]  :
                                   (PW'(gi) == ptr) ? enq_bits : '0;
  end

  assign count     = CW'(ptr) + CW'(1);
  assign load_data = {enq_last, count, word};

  upsizer_out_reg #(
    .DW (HW)
  ) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (enq_fire & closing),
    .load_data (load_data),
    .ready     (deq_ready),
    .valid     (deq_valid),
    .data      (held),
    .can_load  (enq_ready)
  );

  assign {deq_last, deq_count, deq_bits} = held;

endmodule
